// File: rtl/serial_shifter_if.sv
// Request/response bundle for serial_shifter: input handshake with operand and mode,
// output handshake with result.
interface serial_shifter_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   shamt;
    logic             a_l;
    logic             l_r;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;

    modport master (
        output in_valid, din, shamt, a_l, l_r, out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, din, shamt, a_l, l_r, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/serial_shifter.sv
// Multi-cycle shifter: one bit position per clock, valid/ready on request and result.
// Mode encoding {a_l, l_r} matches the combinational barrel shifter.
module serial_shifter #(
    parameter int unsigned  WIDTH = 8,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_shifter_if.slave   bus,
    output logic              busy,
    output logic [7:0]        op_cnt
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;  // {a_l, l_r}
    logic [7:0]       op_cnt_q, op_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        if (!mode_q[0]) begin
            shifted = {data_q[WIDTH-2:0], 1'b0};
        end else if (mode_q[1]) begin
            shifted = {1'b0, data_q[WIDTH-1:1]};
        end else begin
            shifted = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        op_cnt_d = op_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    data_d = bus.din;
                    cnt_d  = bus.shamt;
                    mode_d = {bus.a_l, bus.l_r};
                    if (bus.shamt == '0) begin
                        state_d = StDone;
                        dout_d  = bus.din;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                data_d = shifted;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = StDone;
                    dout_d  = shifted;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d  = StIdle;
                    op_cnt_d = op_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered so in_ready stays low until the first edge after reset release.
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            data_q     <= '0;
            dout_q     <= '0;
            cnt_q      <= '0;
            mode_q     <= '0;
            op_cnt_q   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            dout_q     <= dout_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            op_cnt_q   <= op_cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q == StDone);
    assign bus.dout      = dout_q;
    assign busy          = (state_q != StIdle);
    assign op_cnt        = op_cnt_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: directed cases plus randomized operations
// compared against an arithmetic shift model.
module tb_serial_shifter;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [7:0] op_cnt;

    int         n_checks;
    int         n_errors;
    logic [7:0] exp_cnt;

    serial_shifter_if #(.WIDTH(8)) bus ();

    serial_shifter #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy   (busy),
        .op_cnt (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input int sh, input logic al,
                                         input logic lr);
        logic [7:0] r;
        if (!lr) begin
            r = d << sh;
        end else if (al) begin
            r = d >> sh;
        end else begin
            r = $signed(d) >>> sh;
        end
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_dout", bus.dout, 0);
        check_eq("rst_op_cnt", op_cnt, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        exp_cnt = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("rel_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1 check_eq("rel_in_ready_high", bus.in_ready, 1);
    endtask

    task automatic do_op(input logic [7:0] d, input int sh, input logic al, input logic lr,
                         input int hold);
        logic [7:0] exp;
        int         k;
        exp = model(d, sh, al, lr);
        @(negedge clk);
        check_eq("idle_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.din      = d;
        bus.shamt    = 3'(sh);
        bus.a_l      = al;
        bus.l_r      = lr;
        @(posedge clk);
        #1;
        // Keep requesting with junk operands; the DUT must ignore them while busy.
        bus.din   = 8'($urandom);
        bus.shamt = 3'($urandom);
        bus.a_l   = 1'($urandom);
        bus.l_r   = 1'($urandom);
        k = 0;
        @(negedge clk);
        while (!bus.out_valid && k < 40) begin
            bus.out_ready = 1'($urandom);
            bus.din       = 8'($urandom);
            @(negedge clk);
            k++;
        end
        bus.out_ready = 1'b0;
        check_eq("latency", k, sh);
        check_eq("dout", bus.dout, exp);
        check_eq("done_in_ready", bus.in_ready, 0);
        check_eq("done_busy", busy, 1);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom);
            bus.din      = 8'($urandom);
            @(negedge clk);
            check_eq("hold_out_valid", bus.out_valid, 1);
            check_eq("hold_dout", bus.dout, exp);
            check_eq("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        exp_cnt++;
        check_eq("op_cnt", op_cnt, exp_cnt);
        check_eq("post_out_valid", bus.out_valid, 0);
        check_eq("post_dout", bus.dout, exp);
        check_eq("post_in_ready", bus.in_ready, 1);
        check_eq("post_busy", busy, 0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        exp_cnt       = 8'd0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.din       = '0;
        bus.shamt     = '0;
        bus.a_l       = 1'b0;
        bus.l_r       = 1'b0;

        apply_reset();

        // Zero shift passes the operand straight through.
        do_op(8'hA5, 0, 1'b0, 1'b1, 0);
        do_op(8'hA5, 0, 1'b1, 1'b0, 0);
        do_op(8'h96, 3, 1'b0, 1'b1, 0);
        do_op(8'h96, 3, 1'b1, 1'b1, 0);
        do_op(8'h96, 3, 1'b0, 1'b0, 0);
        do_op(8'h96, 3, 1'b1, 1'b0, 0);
        // Backpressure in DONE.
        do_op(8'h96, 3, 1'b0, 1'b1, 10);

        // Abort mid-shift.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.din      = 8'h80;
        bus.shamt    = 3'd7;
        bus.a_l      = 1'b0;
        bus.l_r      = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid_busy", busy, 1);
        apply_reset();

        do_op(8'h80, 7, 1'b0, 1'b1, 0);
        do_op(8'h80, 7, 1'b1, 1'b1, 0);
        do_op(8'h80, 7, 1'b0, 1'b0, 0);
        do_op(8'h81, 7, 1'b1, 1'b0, 1);

        apply_reset();
        for (int n = 0; n < 256; n++) begin
            do_op(8'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)));
        end
        check_eq("op_cnt_wrap", op_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
